// File: rtl/req_fifo_arbiter_if.sv
// Requester / request-FIFO write-side bundle for the request FIFO arbiter.
// master: the requesters plus the FIFO full flag; slave: the arbiter.
interface req_fifo_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 32
);
    localparam int PTR_W = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ-1:0]        req_lock;
    logic [NUM_REQ*DATA_W-1:0] req_data;
    logic [NUM_REQ-1:0]        req_ready;
    logic                      fifo_wrreq;
    logic [DATA_W-1:0]         fifo_data;
    logic                      fifo_wrfull;
    logic                      arb_locked;
    logic [PTR_W-1:0]          arb_owner;

    modport master (
        output req_valid, req_lock, req_data, fifo_wrfull,
        input  req_ready, fifo_wrreq, fifo_data, arb_locked, arb_owner
    );

    modport slave (
        input  req_valid, req_lock, req_data, fifo_wrfull,
        output req_ready, fifo_wrreq, fifo_data, arb_locked, arb_owner
    );
endinterface

// File: rtl/req_fifo_arbiter.sv
// Round-robin arbiter sharing the CPU request FIFO write port between
// NUM_REQ requesters, with locked bursts so a multi-word message lands
// in the FIFO contiguously. The grant is combinational from registered
// state, so a word moves in the same cycle it is offered.
//
// state | meaning
// ARB   | round-robin scan from rr_ptr, any valid requester may win
// LOCK  | only owner may write; ends on lock drop, burst cap or idle timeout
module req_fifo_arbiter #(
    parameter int NUM_REQ      = 4,
    parameter int DATA_W       = 32,
    parameter int MAX_BURST    = 8,
    parameter int LOCK_TIMEOUT = 16
) (
    input  logic                clk_i,
    input  logic                rst_i,
    req_fifo_arbiter_if.slave   bus
);
    localparam int PTR_W  = $clog2(NUM_REQ);
    localparam int BEAT_W = $clog2(MAX_BURST + 1);
    localparam int IDLE_W = $clog2(LOCK_TIMEOUT + 1);

    typedef enum logic {ST_ARB, ST_LOCK} state_t;

    state_t              state_q, state_d;
    logic [PTR_W-1:0]    rr_ptr_q, rr_ptr_d;
    logic [PTR_W-1:0]    owner_q, owner_d;
    logic [BEAT_W-1:0]   beat_cnt_q, beat_cnt_d;
    logic [IDLE_W-1:0]   idle_cnt_q, idle_cnt_d;

    logic                grant_vld;
    logic [PTR_W-1:0]    grant_idx;
    logic                xfer;
    logic [PTR_W-1:0]    owner_nxt;
    logic [BEAT_W-1:0]   beat_inc;
    logic [IDLE_W-1:0]   idle_inc;
    int                  idx;

    assign owner_nxt = (owner_q == PTR_W'(NUM_REQ - 1)) ? '0 : owner_q + PTR_W'(1);
    assign beat_inc  = beat_cnt_q + BEAT_W'(1);
    assign idle_inc  = idle_cnt_q + IDLE_W'(1);

    // Grant selection, transfer qualification and next-state logic.
    always_comb begin
        state_d    = state_q;
        rr_ptr_d   = rr_ptr_q;
        owner_d    = owner_q;
        beat_cnt_d = beat_cnt_q;
        idle_cnt_d = idle_cnt_q;
        grant_vld  = 1'b0;
        grant_idx  = '0;
        idx        = 0;

        if (state_q == ST_ARB) begin
            // Scan downward so the lowest offset from rr_ptr wins last.
            for (int k = NUM_REQ - 1; k >= 0; k--) begin
                idx = (int'(rr_ptr_q) + k) % NUM_REQ;
                if (bus.req_valid[idx]) begin
                    grant_vld = 1'b1;
                    grant_idx = PTR_W'(idx);
                end
            end
        end else begin
            grant_vld = bus.req_valid[owner_q];
            grant_idx = owner_q;
        end

        // A reset cycle never writes, so a burst cut by reset loses that beat.
        xfer = grant_vld && !bus.fifo_wrfull && !rst_i;

        if (state_q == ST_ARB) begin
            if (xfer) begin
                owner_d = grant_idx;
                if (bus.req_lock[grant_idx] && (MAX_BURST > 1)) begin
                    state_d    = ST_LOCK;
                    beat_cnt_d = BEAT_W'(1);
                    idle_cnt_d = '0;
                end else begin
                    rr_ptr_d = (grant_idx == PTR_W'(NUM_REQ - 1)) ? '0 : grant_idx + PTR_W'(1);
                end
            end
        end else begin
            if (xfer) begin
                beat_cnt_d = beat_inc;
                idle_cnt_d = '0;
                if (!bus.req_lock[owner_q] || (beat_inc == BEAT_W'(MAX_BURST))) begin
                    state_d    = ST_ARB;
                    rr_ptr_d   = owner_nxt;
                    beat_cnt_d = '0;
                end
            end else if (!bus.fifo_wrfull && !bus.req_valid[owner_q]) begin
                // Only a silent owner ages the lock; a full FIFO never does.
                idle_cnt_d = idle_inc;
                if (idle_inc == IDLE_W'(LOCK_TIMEOUT)) begin
                    state_d    = ST_ARB;
                    rr_ptr_d   = owner_nxt;
                    beat_cnt_d = '0;
                    idle_cnt_d = '0;
                end
            end
        end
    end

    // Handshake and status outputs, forced idle while reset is asserted.
    always_comb begin
        bus.req_ready  = xfer ? (NUM_REQ'(1) << grant_idx) : '0;
        bus.fifo_wrreq = xfer;
        bus.fifo_data  = xfer ? bus.req_data[grant_idx*DATA_W +: DATA_W] : '0;
        bus.arb_locked = (state_q == ST_LOCK) && !rst_i;
        bus.arb_owner  = rst_i ? '0 : owner_q;
    end

    // Arbitration state registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= ST_ARB;
            rr_ptr_q   <= '0;
            owner_q    <= '0;
            beat_cnt_q <= '0;
            idle_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            owner_q    <= owner_d;
            beat_cnt_q <= beat_cnt_d;
            idle_cnt_q <= idle_cnt_d;
        end
    end
endmodule

// File: tb/tb_req_fifo_arbiter.sv
// Directed bench for req_fifo_arbiter: reset, fairness, bursts, burst cap,
// lock timeout, FIFO-full stall and reset in the middle of a burst.
module tb_req_fifo_arbiter;
    localparam int NUM_REQ = 4;
    localparam int DATA_W  = 32;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   errors = 0;
    int   checks = 0;

    logic [DATA_W-1:0] dw [NUM_REQ];

    req_fifo_arbiter_if #(.NUM_REQ(NUM_REQ), .DATA_W(DATA_W)) bus ();

    req_fifo_arbiter #(
        .NUM_REQ(NUM_REQ), .DATA_W(DATA_W), .MAX_BURST(8), .LOCK_TIMEOUT(16)
    ) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic do_reset();
        rst = 1'b1;
        bus.req_valid   = '0;
        bus.req_lock    = '0;
        bus.fifo_wrfull = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.req_valid   = 4'b1111;
        bus.req_lock    = '0;
        bus.fifo_wrfull = 1'b0;
        @(negedge clk);
        #1;
        checks++; if (bus.req_ready !== 4'b0000) begin errors++; $display("FAIL rst_ready got %b exp 0000", bus.req_ready); end
        checks++; if (bus.fifo_wrreq !== 1'b0) begin errors++; $display("FAIL rst_wrreq got %b exp 0", bus.fifo_wrreq); end
        checks++; if (bus.arb_locked !== 1'b0) begin errors++; $display("FAIL rst_locked got %b exp 0", bus.arb_locked); end
        checks++; if (bus.arb_owner !== 2'd0) begin errors++; $display("FAIL rst_owner got %0d exp 0", bus.arb_owner); end
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks++; if (bus.req_ready !== 4'b0001) begin errors++; $display("FAIL post_rst_ready got %b exp 0001", bus.req_ready); end
        checks++; if (bus.fifo_wrreq !== 1'b1) begin errors++; $display("FAIL post_rst_wrreq got %b exp 1", bus.fifo_wrreq); end
        checks++; if (bus.fifo_data !== dw[0]) begin errors++; $display("FAIL post_rst_data got %h exp %h", bus.fifo_data, dw[0]); end
        @(negedge clk);
    endtask

    task automatic test_fairness();
        logic [3:0] exp_rdy;
        do_reset();
        bus.req_valid = 4'b1111;
        for (int c = 0; c < 8; c++) begin
            exp_rdy = 4'b0001 << (c % 4);
            #1;
            checks++; if (bus.req_ready !== exp_rdy) begin errors++; $display("FAIL fair_ready cyc%0d got %b exp %b", c, bus.req_ready, exp_rdy); end
            checks++; if (bus.fifo_wrreq !== 1'b1) begin errors++; $display("FAIL fair_wrreq cyc%0d got %b exp 1", c, bus.fifo_wrreq); end
            checks++; if (bus.fifo_data !== dw[c % 4]) begin errors++; $display("FAIL fair_data cyc%0d got %h exp %h", c, bus.fifo_data, dw[c % 4]); end
            if (c > 0) begin
                checks++; if (bus.arb_owner !== 2'((c - 1) % 4)) begin errors++; $display("FAIL fair_owner cyc%0d got %0d exp %0d", c, bus.arb_owner, (c - 1) % 4); end
            end
            @(negedge clk);
        end
    endtask

    task automatic test_burst();
        // cyc0 req0, cyc1..4 req1 burst (lock dropped on beat 4), cyc5 req2
        logic [3:0] exp_rdy [6] = '{4'b0001, 4'b0010, 4'b0010, 4'b0010, 4'b0010, 4'b0100};
        logic       exp_lck [6] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
        do_reset();
        bus.req_valid = 4'b0111;
        for (int c = 0; c < 6; c++) begin
            bus.req_lock = (c < 4) ? 4'b0010 : 4'b0000;
            #1;
            checks++; if (bus.req_ready !== exp_rdy[c]) begin errors++; $display("FAIL burst_ready cyc%0d got %b exp %b", c, bus.req_ready, exp_rdy[c]); end
            checks++; if (bus.arb_locked !== exp_lck[c]) begin errors++; $display("FAIL burst_locked cyc%0d got %b exp %b", c, bus.arb_locked, exp_lck[c]); end
            checks++; if (bus.fifo_wrreq !== 1'b1) begin errors++; $display("FAIL burst_wrreq cyc%0d got %b exp 1", c, bus.fifo_wrreq); end
            @(negedge clk);
        end
    endtask

    task automatic test_burst_cap();
        do_reset();
        bus.req_valid = 4'b1000;
        bus.req_lock  = 4'b1000;
        for (int c = 0; c < 8; c++) begin
            #1;
            checks++; if (bus.req_ready !== 4'b1000) begin errors++; $display("FAIL cap_ready beat%0d got %b exp 1000", c + 1, bus.req_ready); end
            checks++; if (bus.fifo_data !== dw[3]) begin errors++; $display("FAIL cap_data beat%0d got %h exp %h", c + 1, bus.fifo_data, dw[3]); end
            checks++; if (bus.arb_locked !== (c != 0)) begin errors++; $display("FAIL cap_locked beat%0d got %b exp %b", c + 1, bus.arb_locked, c != 0); end
            @(negedge clk);
            bus.req_valid = 4'b1111;
        end
        #1;
        checks++; if (bus.arb_locked !== 1'b0) begin errors++; $display("FAIL cap_release got %b exp 0", bus.arb_locked); end
        checks++; if (bus.req_ready !== 4'b0001) begin errors++; $display("FAIL cap_wrap_ready got %b exp 0001", bus.req_ready); end
        checks++; if (bus.arb_owner !== 2'd3) begin errors++; $display("FAIL cap_owner got %0d exp 3", bus.arb_owner); end
        @(negedge clk);
    endtask

    task automatic test_timeout();
        do_reset();
        bus.req_valid = 4'b0100;
        bus.req_lock  = 4'b0100;
        #1;
        checks++; if (bus.req_ready !== 4'b0100) begin errors++; $display("FAIL to_lock_ready got %b exp 0100", bus.req_ready); end
        @(negedge clk);
        bus.req_valid = 4'b1011;
        for (int c = 1; c <= 16; c++) begin
            #1;
            checks++; if (bus.arb_locked !== 1'b1 || bus.req_ready !== 4'b0000) begin
                errors++; $display("FAIL to_idle cyc%0d got locked=%b ready=%b exp locked=1 ready=0000", c, bus.arb_locked, bus.req_ready);
            end
            @(negedge clk);
        end
        #1;
        checks++; if (bus.arb_locked !== 1'b0) begin errors++; $display("FAIL to_release got %b exp 0", bus.arb_locked); end
        checks++; if (bus.req_ready !== 4'b1000) begin errors++; $display("FAIL to_next_ready got %b exp 1000", bus.req_ready); end
        @(negedge clk);

        // Same lock, but the FIFO is full the whole time: no timeout.
        do_reset();
        bus.req_valid = 4'b0100;
        bus.req_lock  = 4'b0100;
        @(negedge clk);
        bus.req_valid   = 4'b1011;
        bus.fifo_wrfull = 1'b1;
        for (int c = 1; c <= 20; c++) begin
            #1;
            checks++; if (bus.arb_locked !== 1'b1 || bus.fifo_wrreq !== 1'b0) begin
                errors++; $display("FAIL to_full cyc%0d got locked=%b wrreq=%b exp locked=1 wrreq=0", c, bus.arb_locked, bus.fifo_wrreq);
            end
            @(negedge clk);
        end
        bus.fifo_wrfull = 1'b0;
        #1;
        checks++; if (bus.arb_locked !== 1'b1) begin errors++; $display("FAIL to_full_hold got %b exp 1", bus.arb_locked); end
        @(negedge clk);
    endtask

    task automatic test_full();
        do_reset();
        bus.req_valid = 4'b1111;
        #1;
        checks++; if (bus.req_ready !== 4'b0001) begin errors++; $display("FAIL full_pre got %b exp 0001", bus.req_ready); end
        @(negedge clk);
        bus.fifo_wrfull = 1'b1;
        for (int c = 0; c < 5; c++) begin
            #1;
            checks++; if (bus.req_ready !== 4'b0000 || bus.fifo_wrreq !== 1'b0 || bus.fifo_data !== '0) begin
                errors++; $display("FAIL full_stall cyc%0d got ready=%b wrreq=%b data=%h exp 0000/0/0", c, bus.req_ready, bus.fifo_wrreq, bus.fifo_data);
            end
            @(negedge clk);
        end
        bus.fifo_wrfull = 1'b0;
        #1;
        checks++; if (bus.req_ready !== 4'b0010) begin errors++; $display("FAIL full_resume got %b exp 0010", bus.req_ready); end
        checks++; if (bus.fifo_data !== dw[1]) begin errors++; $display("FAIL full_resume_data got %h exp %h", bus.fifo_data, dw[1]); end
        @(negedge clk);
    endtask

    task automatic test_reset_mid_burst();
        do_reset();
        bus.req_valid = 4'b0010;
        bus.req_lock  = 4'b0010;
        @(negedge clk);
        #1;
        checks++; if (bus.arb_locked !== 1'b1) begin errors++; $display("FAIL mid_locked got %b exp 1", bus.arb_locked); end
        @(negedge clk);
        rst = 1'b1;
        bus.req_valid = 4'b1111;
        #1;
        checks++; if (bus.fifo_wrreq !== 1'b0 || bus.req_ready !== 4'b0000) begin
            errors++; $display("FAIL mid_rst_write got wrreq=%b ready=%b exp 0/0000", bus.fifo_wrreq, bus.req_ready);
        end
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks++; if (bus.arb_locked !== 1'b0) begin errors++; $display("FAIL mid_after_locked got %b exp 0", bus.arb_locked); end
        checks++; if (bus.req_ready !== 4'b0001) begin errors++; $display("FAIL mid_after_ready got %b exp 0001", bus.req_ready); end
        @(negedge clk);
    endtask

    initial begin
        for (int i = 0; i < NUM_REQ; i++) dw[i] = 32'hC0DE_0000 + 32'(i * 32'h1111);
        bus.req_data    = {dw[3], dw[2], dw[1], dw[0]};
        bus.req_valid   = '0;
        bus.req_lock    = '0;
        bus.fifo_wrfull = 1'b0;
        test_reset();
        test_fairness();
        test_burst();
        test_burst_cap();
        test_timeout();
        test_full();
        test_reset_mid_burst();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
